// File: rtl/alpresq_if.sv
// alpresq_if: bundles the data, shift-link, zero-chain and iteration signals of one
// R/Q result slice. The master drives the slice inputs; the slave is the slice itself.
`default_nettype none

interface alpresq_if #(
    parameter int WIDTH     = 4,
    parameter int STEP_BITS = 5
);
    logic [WIDTH-1:0]     aluq_h;
    logic [1:0]           rop_h;
    logic [1:0]           qop_h;
    logic                 r_sin_lo_h;
    logic                 r_sin_hi_h;
    logic                 q_sin_lo_h;
    logic                 q_sin_hi_h;
    logic                 r_sout_hi_h;
    logic                 r_sout_lo_h;
    logic                 q_sout_hi_h;
    logic                 q_sout_lo_h;
    logic [WIDTH-1:0]     r_h;
    logic [WIDTH-1:0]     q_h;
    logic                 z_in_h;
    logic                 z_h;
    logic                 it_start_h;
    logic [STEP_BITS-1:0] it_cnt_h;
    logic                 it_step_h;
    logic                 it_busy_h;
    logic                 it_done_h;
    logic [STEP_BITS-1:0] it_val_h;

    modport master (
        output aluq_h, rop_h, qop_h, r_sin_lo_h, r_sin_hi_h, q_sin_lo_h, q_sin_hi_h,
               z_in_h, it_start_h, it_cnt_h, it_step_h,
        input  r_sout_hi_h, r_sout_lo_h, q_sout_hi_h, q_sout_lo_h, r_h, q_h, z_h,
               it_busy_h, it_done_h, it_val_h
    );

    modport slave (
        input  aluq_h, rop_h, qop_h, r_sin_lo_h, r_sin_hi_h, q_sin_lo_h, q_sin_hi_h,
               z_in_h, it_start_h, it_cnt_h, it_step_h,
        output r_sout_hi_h, r_sout_lo_h, q_sout_hi_h, q_sout_lo_h, r_h, q_h, z_h,
               it_busy_h, it_done_h, it_val_h
    );
endinterface

`default_nettype wire

// File: rtl/alpresq.sv
//------------------------------------------------------------------------------
// Module     : alpresq
// Description: Result/Q register slice behind the ALP ALU slice, with shift links,
//              zero chain and the mul/div iteration counter.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alpresq #(
    parameter int WIDTH     = 4,
    parameter int STEP_BITS = 5
) (
    input  logic      clk_h,
    input  logic      reset_l,
    alpresq_if.slave  bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } it_state_t;

    logic [WIDTH-1:0]     r_reg;
    logic [WIDTH-1:0]     q_reg;
    logic                 z_reg;
    logic [STEP_BITS-1:0] cnt;
    logic                 done;
    it_state_t            state;

    logic [WIDTH-1:0]     r_next;
    logic [WIDTH-1:0]     q_next;

    always_comb begin
        r_next = bus.aluq_h;
        case (bus.rop_h)
            2'b00:   r_next = r_reg;
            2'b10:   r_next = {bus.aluq_h[WIDTH-2:0], bus.r_sin_lo_h};
            2'b11:   r_next = {bus.r_sin_hi_h, bus.aluq_h[WIDTH-1:1]};
            default: r_next = bus.aluq_h;
        endcase
    end

    always_comb begin
        q_next = q_reg;
        case (bus.qop_h)
            2'b01:   q_next = bus.aluq_h;
            2'b10:   q_next = {q_reg[WIDTH-2:0], bus.q_sin_lo_h};
            2'b11:   q_next = {bus.q_sin_hi_h, q_reg[WIDTH-1:1]};
            default: q_next = q_reg;
        endcase
    end

    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            r_reg <= '0;
            q_reg <= '0;
            z_reg <= 1'b1;
        end else begin
            r_reg <= r_next;
            q_reg <= q_next;
            if (bus.rop_h != 2'b00)
                z_reg <= bus.z_in_h & (r_next == '0);
        end
    end

    // Start has priority over step so a restart never emits a done for the aborted run.
    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.it_start_h) begin
                cnt <= bus.it_cnt_h;
                if (bus.it_cnt_h == '0) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end else begin
                    state <= BUSY;
                end
            end else if (state == BUSY && bus.it_step_h) begin
                cnt <= cnt - STEP_BITS'(1);
                if (cnt == STEP_BITS'(1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign bus.r_h         = r_reg;
    assign bus.q_h         = q_reg;
    assign bus.z_h         = z_reg;
    assign bus.r_sout_hi_h = bus.aluq_h[WIDTH-1];
    assign bus.r_sout_lo_h = bus.aluq_h[0];
    assign bus.q_sout_hi_h = q_reg[WIDTH-1];
    assign bus.q_sout_lo_h = q_reg[0];
    assign bus.it_busy_h   = (state == BUSY);
    assign bus.it_done_h   = done;
    assign bus.it_val_h    = cnt;

endmodule

`default_nettype wire
